plic_irq_filter: RTL and testbench



---
 rtl/plic_irq_filter_if.sv | 24 ++
 rtl/plic_irq_filter.sv | 80 ++++++++
 tb/tb_plic_irq_filter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/plic_irq_filter_if.sv
// Signal bundle between the interrupt conditioning stage and its driver.
// Plain levels, no handshake: every signal is sampled on each rising clock edge.
interface plic_irq_filter_if #(
  parameter int N_SOURCE  = 30,
  parameter int FILT_CNTW = 4
);
  logic [N_SOURCE-1:0]  irq_async_i;
  logic [N_SOURCE-1:0]  filt_en_i;
  logic [FILT_CNTW-1:0] filt_len_i;
  logic [N_SOURCE-1:0]  glitch_clr_i;
  logic [N_SOURCE-1:0]  irq_sources_o;
  logic [N_SOURCE-1:0]  rise_o;
  logic [N_SOURCE-1:0]  glitch_o;

  modport master (
    output irq_async_i, filt_en_i, filt_len_i, glitch_clr_i,
    input  irq_sources_o, rise_o, glitch_o
  );

  modport slave (
    input  irq_async_i, filt_en_i, filt_len_i, glitch_clr_i,
    output irq_sources_o, rise_o, glitch_o
  );
endinterface

// File: rtl/plic_irq_filter.sv
// Per-source synchroniser, polarity fix and debounce filter ahead of the PLIC,
// with rising-edge pulses and sticky glitch flags.
module plic_irq_filter #(
  parameter int                  N_SOURCE    = 30,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  FILT_CNTW   = 4,
  parameter logic [N_SOURCE-1:0] INV_MASK    = '0
) (
  input logic              clk_i,
  input logic              rst_i,
  plic_irq_filter_if.slave bus
);

  logic [N_SOURCE-1:0]  sync_q [SYNC_STAGES];
  logic [N_SOURCE-1:0]  s;
  logic [N_SOURCE-1:0]  out_q, out_d;
  logic [N_SOURCE-1:0]  prev_q;
  logic [N_SOURCE-1:0]  glitch_q, glitch_d;
  logic [FILT_CNTW-1:0] cnt_q [N_SOURCE];
  logic [FILT_CNTW-1:0] cnt_d [N_SOURCE];
  logic [FILT_CNTW:0]   len_ext;
  logic [FILT_CNTW:0]   inc;
  logic                 len_zero;

  // Reset loads INV_MASK so the normalised level starts inactive.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= INV_MASK;
    end else begin
      sync_q[0] <= bus.irq_async_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s        = sync_q[SYNC_STAGES-1] ^ INV_MASK;
  assign len_ext  = {1'b0, bus.filt_len_i};
  assign len_zero = (bus.filt_len_i == '0);

  // Counter compare runs one bit wider than the counter so cnt+1 never wraps.
  always_comb begin
    out_d    = out_q;
    glitch_d = glitch_q & ~bus.glitch_clr_i;
    inc      = '0;
    for (int k = 0; k < N_SOURCE; k++) begin
      cnt_d[k] = cnt_q[k];
      inc      = {1'b0, cnt_q[k]} + (FILT_CNTW+1)'(1);
      if (!bus.filt_en_i[k] || len_zero) begin
        out_d[k] = s[k];
        cnt_d[k] = '0;
      end else if (s[k] == out_q[k]) begin
        cnt_d[k] = '0;
        if (cnt_q[k] != '0) glitch_d[k] = 1'b1;
      end else if (inc >= len_ext) begin
        out_d[k] = s[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = inc[FILT_CNTW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q    <= '0;
      prev_q   <= '0;
      glitch_q <= '0;
      for (int k = 0; k < N_SOURCE; k++) cnt_q[k] <= '0;
    end else begin
      out_q    <= out_d;
      prev_q   <= out_q;
      glitch_q <= glitch_d;
      for (int k = 0; k < N_SOURCE; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign bus.irq_sources_o = out_q;
  assign bus.rise_o        = out_q & ~prev_q;
  assign bus.glitch_o      = glitch_q;

endmodule

// File: tb/tb_plic_irq_filter.sv
// Table-driven bench for plic_irq_filter: each record is one clock edge of
// stimulus plus the outputs expected right after that edge.
module tb_plic_irq_filter;

  localparam int N = 30;
  localparam int W = 3 * N;
  localparam logic [N-1:0] P0  = 30'h1;
  localparam logic [N-1:0] B2  = 30'h4;
  localparam logic [N-1:0] B3  = 30'h8;
  localparam logic [N-1:0] B5  = 30'h20;
  localparam logic [N-1:0] B7  = 30'h80;
  localparam logic [N-1:0] B9  = 30'h200;
  localparam logic [N-1:0] B11 = 30'h800;
  localparam logic [N-1:0] Z   = 30'h0;

  typedef struct {
    string        nm;
    logic         rst;
    logic [N-1:0] pins;
    logic [N-1:0] en;
    logic [3:0]   len;
    logic [N-1:0] clr;
    logic [N-1:0] src;
    logic [N-1:0] rise;
    logic [N-1:0] gl;
  } vec_t;

  logic clk;
  logic rst;
  vec_t vecs[$];
  logic [W-1:0] exp_q[$];
  logic hist_q[$];
  int n_vec;
  int n_err;

  plic_irq_filter_if #(.N_SOURCE(N), .FILT_CNTW(4)) bus ();

  plic_irq_filter #(
    .N_SOURCE(N), .SYNC_STAGES(2), .FILT_CNTW(4), .INV_MASK(30'h1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(string nm, logic r, logic [N-1:0] pins, logic [N-1:0] en,
                              logic [3:0] len, logic [N-1:0] clr, logic [N-1:0] src,
                              logic [N-1:0] rise, logic [N-1:0] gl);
    vec_t v;
    v.nm = nm; v.rst = r; v.pins = pins; v.en = en; v.len = len;
    v.clr = clr; v.src = src; v.rise = rise; v.gl = gl;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, logic [W-1:0] mask);
    logic [W-1:0] got;
    logic [W-1:0] expv;
    got  = {bus.irq_sources_o, bus.rise_o, bus.glitch_o};
    expv = exp_q.pop_front();
    n_vec++;
    if (((got ^ expv) & mask) != '0) begin
      n_err++;
      $display("FAIL %s (vec %0d) got src=%h rise=%h glitch=%h want src=%h rise=%h glitch=%h",
               nm, n_vec, got[3*N-1:2*N], got[2*N-1:N], got[N-1:0],
               expv[3*N-1:2*N], expv[2*N-1:N], expv[N-1:0]);
    end
  endtask

  // driver: one record per edge, expected value queued as stimulus goes out
  task automatic apply(vec_t v);
    @(negedge clk);
    rst              = v.rst;
    bus.irq_async_i  = v.pins | P0;
    bus.filt_en_i    = v.en;
    bus.filt_len_i   = v.len;
    bus.glitch_clr_i = v.clr;
    exp_q.push_back({v.src, v.rise, v.gl});
    @(posedge clk);
    #1;
    check(v.nm, '1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst              = 1'b1;
    bus.irq_async_i  = P0;
    bus.filt_en_i    = '0;
    bus.filt_len_i   = '0;
    bus.glitch_clr_i = '0;

    // reset then idle with pin0 held at its inactive (high) level
    add("reset", 1, Z, Z, 0, Z, Z, Z, Z);
    add("reset", 1, Z, Z, 0, Z, Z, Z, Z);
    for (int i = 0; i < 20; i++) add("idle", 0, Z, Z, 0, Z, Z, Z, Z);

    // bypass: two-cycle pulse on pin3 shows up three edges later
    add("bypass", 0, B3, Z, 0, Z, Z, Z, Z);
    add("bypass", 0, B3, Z, 0, Z, Z, Z, Z);
    add("bypass", 0, Z,  Z, 0, Z, B3, B3, Z);
    add("bypass", 0, Z,  Z, 0, Z, B3, Z, Z);
    add("bypass", 0, Z,  Z, 0, Z, Z, Z, Z);
    add("bypass", 0, Z,  Z, 0, Z, Z, Z, Z);

    // filter accept on pin5 with L=4, then release back low
    for (int i = 0; i < 5; i++) add("accept", 0, B5, B5, 4, Z, Z, Z, Z);
    add("accept", 0, B5, B5, 4, Z, B5, B5, Z);
    add("accept", 0, B5, B5, 4, Z, B5, Z, Z);
    add("accept", 0, B5, B5, 4, Z, B5, Z, Z);
    for (int i = 0; i < 5; i++) add("release", 0, Z, B5, 4, Z, B5, Z, Z);
    add("release", 0, Z, B5, 4, Z, Z, Z, Z);

    // glitch reject on pin7, clear, then clear colliding with a new rejection
    add("glitch", 0, B7, B7, 4, Z, Z, Z, Z);
    add("glitch", 0, B7, B7, 4, Z, Z, Z, Z);
    add("glitch", 0, Z,  B7, 4, Z, Z, Z, Z);
    add("glitch", 0, Z,  B7, 4, Z, Z, Z, Z);
    for (int i = 0; i < 3; i++) add("glitch_hold", 0, Z, B7, 4, Z, Z, Z, B7);
    add("glitch_clr", 0, Z, B7, 4, B7, Z, Z, Z);
    add("glitch_clr", 0, Z, B7, 4, Z,  Z, Z, Z);
    add("glitch2", 0, B7, B7, 4, Z, Z, Z, Z);
    add("glitch2", 0, B7, B7, 4, Z, Z, Z, Z);
    add("glitch2", 0, Z,  B7, 4, Z, Z, Z, Z);
    add("glitch2", 0, Z,  B7, 4, Z, Z, Z, Z);
    add("set_wins", 0, Z, B7, 4, B7, Z, Z, B7);
    add("set_wins", 0, Z, B7, 4, Z,  Z, Z, B7);

    // length shortened mid-count on pin2, then bypass release
    for (int i = 0; i < 5; i++) add("midlen", 0, B2, B2, 8, Z, Z, Z, B7);
    add("midlen", 0, B2, B2, 2, Z, B2, B2, B7);
    add("midlen", 0, B2, B2, 2, Z, B2, Z, B7);
    add("midlen_off", 0, Z, Z, 2, Z, B2, Z, B7);
    add("midlen_off", 0, Z, Z, 2, Z, B2, Z, B7);
    add("midlen_off", 0, Z, Z, 2, Z, Z,  Z, B7);

    // reset in the middle of a count on pin9, pin3 bypassed alongside
    add("rstmid", 0, B9|B3, B9, 8, Z, Z, Z, B7);
    add("rstmid", 0, B9|B3, B9, 8, Z, Z, Z, B7);
    add("rstmid", 0, B9|B3, B9, 8, Z, B3, B3, B7);
    for (int i = 0; i < 4; i++) add("rstmid", 0, B9|B3, B9, 8, Z, B3, Z, B7);
    add("rstmid_rst", 1, B9|B3, B9, 8, Z, Z, Z, Z);
    add("rstmid_post", 0, B9|B3, B9, 8, Z, Z, Z, Z);
    add("rstmid_post", 0, B9|B3, B9, 8, Z, Z, Z, Z);
    add("rstmid_post", 0, B9|B3, B9, 8, Z, B3, B3, Z);
    for (int i = 0; i < 6; i++) add("rstmid_post", 0, B9|B3, B9, 8, Z, B3, Z, Z);
    add("rstmid_post", 0, B9|B3, B9, 8, Z, B3|B9, B9, Z);
    add("rstmid_post", 0, B9|B3, B9, 8, Z, B3|B9, Z, Z);

    foreach (vecs[i]) apply(vecs[i]);

    // L=1 on pin11 with random pins: must track the pin exactly as bypass does
    for (int i = 0; i < 3; i++) hist_q.push_back(1'b0);
    for (int i = 0; i < 40; i++) begin
      logic b;
      logic e_src;
      logic e_rise;
      b = 1'(($urandom_range(0, 1)));
      @(negedge clk);
      rst              = 1'b0;
      bus.irq_async_i  = P0 | (b ? B11 : Z);
      bus.filt_en_i    = B11;
      bus.filt_len_i   = 4'd1;
      bus.glitch_clr_i = '0;
      hist_q.push_back(b);
      e_src  = hist_q[hist_q.size()-3];
      e_rise = e_src & ~hist_q[hist_q.size()-4];
      exp_q.push_back({(e_src ? B11 : Z), (e_rise ? B11 : Z), Z});
      @(posedge clk);
      #1;
      check("len1", {B11, B11, B11});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
